// File: rtl/im_loader.sv
// Instruction-memory loader: parses a header/payload stream and fans the
// payload words out to one of NUM_ID decoder memories or NUM_IMM immediate
// memories through one-hot write strobes on a shared address/data bus.
module im_loader #(
   parameter int I_WIDTH           = 12,
   parameter int I_IMM_WIDTH       = 33,
   parameter int IM_MEM_ADDR_WIDTH = 8,
   parameter int NUM_ID            = 10,
   parameter int NUM_IMM           = 4
) (
   input  logic                          iClk,
   input  logic                          iReset,
   input  logic                          iStart,
   input  logic                          iStream_Valid,
   input  logic [I_IMM_WIDTH-1:0]        iStream_Data,
   output logic                          oStream_Ready,
   output logic [NUM_ID+NUM_IMM-1:0]     oIM_WriteEnable,
   output logic [IM_MEM_ADDR_WIDTH-1:0]  oIM_WriteAddress,
   output logic [I_WIDTH-1:0]            oIM_WriteData,
   output logic [I_IMM_WIDTH-1:0]        oIM_WriteData_IMM,
   output logic                          oCGRA_Hold,
   output logic                          oBusy,
   output logic                          oDone,
   output logic                          oError
);

   localparam int A       = IM_MEM_ADDR_WIDTH;
   localparam int NUM_MEM = NUM_ID + NUM_IMM;

   typedef enum logic [2:0] {
      IDLE,
      HEADER,
      DATA,
      SKIP,
      DONE
   } state_t;

   state_t             state;
   logic [4:0]         sel;
   logic [A-1:0]       addr;
   logic [A-1:0]       cnt;
   logic               accept;
   logic [4:0]         hdr_sel;
   logic [A-1:0]       hdr_base;
   logic [A-1:0]       hdr_cnt;
   logic [NUM_MEM-1:0] sel_onehot;

   // Header field extraction; bits above the count field are don't-care.
   always_comb begin
      hdr_sel  = iStream_Data[4:0];
      hdr_base = iStream_Data[A+4:5];
      hdr_cnt  = iStream_Data[2*A+4:A+5];
   end

   // Handshake and status decoded from the state register only.
   always_comb begin
      oStream_Ready = (state == HEADER) || (state == DATA) || (state == SKIP);
      oBusy         = (state != IDLE);
      oDone         = (state == DONE);
      oCGRA_Hold    = oBusy || (|oIM_WriteEnable);
      accept        = iStream_Valid && oStream_Ready;
      sel_onehot    = NUM_MEM'(1) << sel;
   end

   // Session FSM with the registered write port.
   always_ff @(posedge iClk) begin
      if (iReset) begin
         state             <= IDLE;
         sel               <= '0;
         addr              <= '0;
         cnt               <= '0;
         oError            <= 1'b0;
         oIM_WriteEnable   <= '0;
         oIM_WriteAddress  <= '0;
         oIM_WriteData     <= '0;
         oIM_WriteData_IMM <= '0;
      end else begin
         oIM_WriteEnable <= '0;
         case (state)
            IDLE: begin
               if (iStart) begin
                  state  <= HEADER;
                  oError <= 1'b0;
               end
            end
            HEADER: begin
               if (accept) begin
                  if (int'(hdr_sel) < NUM_MEM) begin
                     sel   <= hdr_sel;
                     addr  <= hdr_base;
                     cnt   <= hdr_cnt;
                     state <= DATA;
                  end else if (hdr_sel == 5'd31) begin
                     state <= DONE;
                  end else begin
                     oError <= 1'b1;
                     cnt    <= hdr_cnt;
                     state  <= SKIP;
                  end
               end
            end
            DATA: begin
               if (accept) begin
                  oIM_WriteEnable   <= sel_onehot;
                  oIM_WriteAddress  <= addr;
                  oIM_WriteData     <= iStream_Data[I_WIDTH-1:0];
                  oIM_WriteData_IMM <= iStream_Data;
                  addr              <= addr + A'(1);
                  cnt               <= cnt - A'(1);
                  if (cnt == '0) state <= HEADER;
               end
            end
            SKIP: begin
               if (accept) begin
                  cnt <= cnt - A'(1);
                  if (cnt == '0) state <= HEADER;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: a table of per-cycle stimulus/expectation
// rows followed by a hand-written sequence with random stream gaps.
module tb_im_loader;

   logic        clk;
   logic        rst;
   logic        start;
   logic        valid;
   logic [32:0] data;
   logic        ready;
   logic [13:0] we;
   logic [7:0]  waddr;
   logic [11:0] wdata;
   logic [32:0] wdata_imm;
   logic        hold;
   logic        busy;
   logic        done;
   logic        err;

   int errors = 0;
   int checks = 0;

   im_loader #(
      .I_WIDTH(12),
      .I_IMM_WIDTH(33),
      .IM_MEM_ADDR_WIDTH(8),
      .NUM_ID(10),
      .NUM_IMM(4)
   ) dut (
      .iClk(clk),
      .iReset(rst),
      .iStart(start),
      .iStream_Valid(valid),
      .iStream_Data(data),
      .oStream_Ready(ready),
      .oIM_WriteEnable(we),
      .oIM_WriteAddress(waddr),
      .oIM_WriteData(wdata),
      .oIM_WriteData_IMM(wdata_imm),
      .oCGRA_Hold(hold),
      .oBusy(busy),
      .oDone(done),
      .oError(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        start;
      logic        valid;
      logic [32:0] data;
      logic [13:0] we;
      logic        chk_wr;
      logic [7:0]  addr;
      logic [11:0] wd;
      logic [32:0] wdi;
      logic        rdy;
      logic        busy;
      logic        done;
      logic        err;
      logic        hold;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Header word with junk in the ignored upper bits.
   function automatic logic [32:0] hdr(input int s, input int b, input int c);
      logic [32:0] h;
      h        = '0;
      h[4:0]   = s[4:0];
      h[12:5]  = b[7:0];
      h[20:13] = c[7:0];
      h[32:21] = 12'hA5C;
      return h;
   endfunction

   // Row with no write expected in the following cycle.
   function automatic void ctl(input logic r, input logic s, input logic v, input logic [32:0] d,
                               input logic e_rdy, input logic e_busy, input logic e_done, input logic e_err);
      vec_t x;
      x.rst = r; x.start = s; x.valid = v; x.data = d;
      x.we = '0; x.chk_wr = 1'b0; x.addr = '0; x.wd = '0; x.wdi = '0;
      x.rdy = e_rdy; x.busy = e_busy; x.done = e_done; x.err = e_err; x.hold = e_busy;
      vecs.push_back(x);
   endfunction

   // Reset row: everything including the write bus must be zero.
   function automatic void rstrow(input logic s, input logic v, input logic [32:0] d);
      vec_t x;
      x.rst = 1'b1; x.start = s; x.valid = v; x.data = d;
      x.we = '0; x.chk_wr = 1'b1; x.addr = '0; x.wd = '0; x.wdi = '0;
      x.rdy = 1'b0; x.busy = 1'b0; x.done = 1'b0; x.err = 1'b0; x.hold = 1'b0;
      vecs.push_back(x);
   endfunction

   // Payload word accepted in DATA; the write shows up right after this edge.
   function automatic void wr(input logic [32:0] d, input logic [13:0] e_we, input logic [7:0] e_addr,
                              input logic e_err);
      vec_t x;
      x.rst = 1'b0; x.start = 1'b0; x.valid = 1'b1; x.data = d;
      x.we = e_we; x.chk_wr = 1'b1; x.addr = e_addr; x.wd = d[11:0]; x.wdi = d;
      x.rdy = 1'b1; x.busy = 1'b1; x.done = 1'b0; x.err = e_err; x.hold = 1'b1;
      vecs.push_back(x);
   endfunction

   task automatic cyc(input logic r, input logic s, input logic v, input logic [32:0] d);
      rst = r; start = s; valid = v; data = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int sent;
      int written;
      int n;
      logic acc;

      rst = 1'b1; start = 1'b0; valid = 1'b0; data = '0;

      // basic decoder session: SEL=3, BASE=0x10, three words
      rstrow(1'b0, 1'b0, 33'h0);
      ctl(0, 1, 0, 33'h0,             1, 1, 0, 0);
      ctl(0, 0, 1, hdr(3, 'h10, 2),   1, 1, 0, 0);
      wr(33'hA, 14'h0008, 8'h10, 0);
      wr(33'hB, 14'h0008, 8'h11, 0);
      wr(33'hC, 14'h0008, 8'h12, 0);
      ctl(0, 0, 1, hdr(31, 0, 0),     0, 1, 1, 0);
      ctl(0, 1, 0, 33'h0,             0, 0, 0, 0);   // start ignored in DONE
      ctl(0, 0, 1, 33'h123,           0, 0, 0, 0);   // stream ignored in IDLE
      // immediate memory, full 33-bit payload
      ctl(0, 1, 0, 33'h0,             1, 1, 0, 0);
      ctl(0, 0, 1, hdr(12, 'h20, 0),  1, 1, 0, 0);
      wr(33'h1_2345_6789, 14'h1000, 8'h20, 0);
      ctl(0, 0, 1, hdr(31, 0, 0),     0, 1, 1, 0);
      ctl(0, 0, 0, 33'h0,             0, 0, 0, 0);
      // address wrap with a stall in the middle
      ctl(0, 1, 0, 33'h0,             1, 1, 0, 0);
      ctl(0, 0, 1, hdr(5, 'hFE, 3),   1, 1, 0, 0);
      wr(33'h1, 14'h0020, 8'hFE, 0);
      ctl(0, 0, 0, 33'h999,           1, 1, 0, 0);
      wr(33'h2, 14'h0020, 8'hFF, 0);
      wr(33'h3, 14'h0020, 8'h00, 0);
      wr(33'h4, 14'h0020, 8'h01, 0);
      ctl(0, 0, 1, hdr(31, 0, 0),     0, 1, 1, 0);
      ctl(0, 0, 0, 33'h0,             0, 0, 0, 0);
      // bad select: skipped payload, sticky error until next start
      ctl(0, 1, 0, 33'h0,             1, 1, 0, 0);
      ctl(0, 0, 1, hdr(20, 'h33, 1),  1, 1, 0, 1);
      ctl(0, 0, 1, 33'h55,            1, 1, 0, 1);
      ctl(0, 1, 1, 33'h66,            1, 1, 0, 1);   // start ignored in SKIP
      ctl(0, 0, 1, hdr(31, 0, 0),     0, 1, 1, 1);
      ctl(0, 0, 0, 33'h0,             0, 0, 0, 1);
      ctl(0, 0, 0, 33'h0,             0, 0, 0, 1);
      ctl(0, 1, 0, 33'h0,             1, 1, 0, 0);
      ctl(0, 0, 1, hdr(31, 0, 0),     0, 1, 1, 0);
      ctl(0, 0, 0, 33'h0,             0, 0, 0, 0);
      // reset in the cycle a payload word is accepted
      ctl(0, 1, 0, 33'h0,             1, 1, 0, 0);
      ctl(0, 0, 1, hdr(1, 'h40, 2),   1, 1, 0, 0);
      wr(33'h11, 14'h0002, 8'h40, 0);
      rstrow(1'b0, 1'b1, 33'h22);
      rstrow(1'b1, 1'b0, 33'h0);                    // reset beats start
      ctl(0, 0, 0, 33'h0,             0, 0, 0, 0);
      ctl(0, 1, 0, 33'h0,             1, 1, 0, 0);
      ctl(0, 0, 1, hdr(1, 'h50, 0),   1, 1, 0, 0);
      wr(33'h33, 14'h0002, 8'h50, 0);
      ctl(0, 0, 1, hdr(31, 0, 0),     0, 1, 1, 0);
      ctl(0, 0, 0, 33'h0,             0, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         cyc(vecs[i].rst, vecs[i].start, vecs[i].valid, vecs[i].data);
         chk($sformatf("v%0d_we", i),    64'(we),    64'(vecs[i].we));
         chk($sformatf("v%0d_ready", i), 64'(ready), 64'(vecs[i].rdy));
         chk($sformatf("v%0d_busy", i),  64'(busy),  64'(vecs[i].busy));
         chk($sformatf("v%0d_done", i),  64'(done),  64'(vecs[i].done));
         chk($sformatf("v%0d_error", i), 64'(err),   64'(vecs[i].err));
         chk($sformatf("v%0d_hold", i),  64'(hold),  64'(vecs[i].hold));
         if (vecs[i].chk_wr) begin
            chk($sformatf("v%0d_addr", i), 64'(waddr),     64'(vecs[i].addr));
            chk($sformatf("v%0d_wd", i),   64'(wdata),     64'(vecs[i].wd));
            chk($sformatf("v%0d_wdi", i),  64'(wdata_imm), 64'(vecs[i].wdi));
         end
      end

      // random valid gaps: SEL=7, BASE=0x80, six words
      cyc(0, 1, 0, 33'h0);
      cyc(0, 0, 1, hdr(7, 'h80, 5));
      chk("gap_hdr_busy", 64'(busy), 64'(1));
      sent = 0;
      written = 0;
      n = 0;
      while (sent < 6 && n < 200) begin
         acc = ($urandom_range(0, 2) != 0);
         cyc(0, 0, acc, 33'h100 + 33'(sent));
         n++;
         chk("gap_we", 64'(we), acc ? 64'h80 : 64'h0);
         if (acc) begin
            chk("gap_addr", 64'(waddr), 64'(8'h80 + 8'(written)));
            chk("gap_wdi", 64'(wdata_imm), 64'(33'h100 + 33'(written)));
            sent++;
            written++;
         end
      end
      chk("gap_bound", 64'(n < 200), 64'(1));
      chk("gap_count", 64'(written), 64'(6));
      cyc(0, 0, 0, 33'h0);
      chk("gap_idle_we", 64'(we), 64'(0));
      chk("gap_back_in_header", 64'(ready), 64'(1));
      cyc(0, 0, 1, hdr(31, 0, 0));
      chk("gap_done", 64'(done), 64'(1));
      cyc(0, 0, 0, 33'h0);
      chk("gap_done_pulse", 64'(done), 64'(0));
      chk("gap_idle", 64'(busy), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 SHALL have parameter I_WIDTH, default 12, meaning instruction width of a decoder memory.
REQ-002 SHALL have parameter I_IMM_WIDTH, default 33, meaning instruction width of an immediate memory and width of the load stream.
REQ-003 SHALL have parameter IM_MEM_ADDR_WIDTH (A), default 8, meaning instruction memory address width.
REQ-004 SHALL have parameter NUM_ID, default 10, meaning number of decoder instruction memories.
REQ-005 SHALL have parameter NUM_IMM, default 4, meaning number of immediate instruction memories; NUM_ID+NUM_IMM SHALL be at most 31.
REQ-006 SHALL have port iClk, input, 1, meaning the single clock; all logic is clocked on its rising edge.
REQ-007 SHALL have port iReset, input, 1, meaning reset; it is synchronous and active-high.
REQ-008 SHALL have port iStart, input, 1, meaning a single-cycle request to begin a load session.
REQ-009 SHALL have port iStream_Valid, input, 1, meaning a load stream word is present.
REQ-010 SHALL have port iStream_Data, input, I_IMM_WIDTH, meaning a load stream word (header or payload).
REQ-011 SHALL have port oStream_Ready, output, 1, meaning the loader accepts the word this cycle.
REQ-012 SHALL have port oIM_WriteEnable, output, NUM_ID+NUM_IMM, meaning a one-hot per-memory write strobe.
REQ-013 SHALL have port oIM_WriteAddress, output, A, meaning the shared write address.
REQ-014 SHALL have port oIM_WriteData, output, I_WIDTH, meaning the decoder write data, equal to payload bits [I_WIDTH-1:0].
REQ-015 SHALL have port oIM_WriteData_IMM, output, I_IMM_WIDTH, meaning the immediate write data, equal to the full payload word.
REQ-016 SHALL have port oCGRA_Hold, output, 1, meaning the array is held while the session is active.
REQ-017 SHALL have port oBusy, output, 1, meaning the state is not IDLE.
REQ-018 SHALL have port oDone, output, 1, meaning a one-cycle pulse at the end of a session.
REQ-019 SHALL have port oError, output, 1, meaning a sticky flag that a bad memory select was received.

Function
REQ-020 SHALL implement states IDLE, HEADER, DATA, SKIP and DONE.
REQ-021 A word SHALL transfer only in a cycle where iStream_Valid and oStream_Ready are both 1.
REQ-022 oStream_Ready SHALL be 1 in HEADER, DATA and SKIP, and 0 in IDLE and DONE.
REQ-023 In IDLE, iStart=1 SHALL move the state to HEADER and clear oError.
REQ-024 iStart SHALL be ignored in every state other than IDLE.
REQ-025 The header word SHALL be decoded as: SEL=[4:0], BASE=[A+4:5], CNT=[2A+4:A+5] giving CNT+1 payload words; all higher header bits SHALL be ignored.
REQ-026 A header with SEL<NUM_ID+NUM_IMM SHALL latch SEL, load the address register with BASE, load the word counter with CNT, and move the state to DATA.
REQ-027 A header with SEL=31 SHALL move the state to DONE and consume no payload.
REQ-028 A header with any other SEL SHALL set oError, load the word counter with CNT, and move the state to SKIP.
REQ-029 Each accepted DATA word SHALL, on the next cycle only, drive oIM_WriteEnable with bit SEL set, oIM_WriteAddress with the current address, and both data outputs from that word.
REQ-030 oIM_WriteEnable SHALL be all-zero in every cycle with no such write.
REQ-031 Write latency SHALL be exactly 1 cycle from acceptance.
REQ-032 Each accepted DATA word SHALL increment the address modulo 2^A, so 0xFF wraps to 0x00 for A=8.
REQ-033 Each accepted DATA word SHALL decrement the word counter.
REQ-034 Accepting a DATA word with counter=0 SHALL move the state to HEADER.
REQ-035 SKIP SHALL accept and discard words with no write, and SHALL move to HEADER after CNT+1 words.
REQ-036 DONE SHALL last exactly 1 cycle with oDone=1, then move the state to IDLE.
REQ-037 oCGRA_Hold SHALL equal oBusy OR a write pending in the current cycle, so hold covers the final write.
REQ-038 A stall (iStream_Valid=0) SHALL leave the state, address and counter unchanged and produce no write.
REQ-039 All outputs SHALL be registered or decoded from the state only; no output SHALL combinationally depend on iStream_Data.

Reset
REQ-040 iReset=1 at a clock edge SHALL force IDLE and zero oIM_WriteEnable, oIM_WriteAddress, oIM_WriteData, oIM_WriteData_IMM, oStream_Ready, oCGRA_Hold, oBusy, oDone and oError, plus the internal counters.
REQ-041 Reset SHALL take precedence over iStart and over stream transfers in the same cycle.
REQ-042 Reset mid-session SHALL suppress any pending write in the following cycle, and SHALL leave previously written memory contents untouched.

Verification
REQ-043 The bench SHALL cover: iStart, header SEL=3 BASE=0x10 CNT=2, words 0xA,0xB,0xC with no gaps, then header SEL=31 -> writes to bit 3 at addresses 0x10,0x11,0x12 on cycles acceptance+1; oDone pulses once; then IDLE.
REQ-044 The bench SHALL cover: header SEL=12 (IMM) with a 33-bit word 0x1_2345_6789 -> oIM_WriteData_IMM=0x1_2345_6789, oIM_WriteData=0x789, one-hot bit 12.
REQ-045 The bench SHALL cover: BASE=0xFE, CNT=3 -> addresses 0xFE,0xFF,0x00,0x01.
REQ-046 The bench SHALL cover: header SEL=20, CNT=1, two words, then SEL=31 -> no writes, oError=1 until the next iStart, the session still completes.
REQ-047 The bench SHALL cover: random iStream_Valid gaps during DATA -> write count and addresses identical to the gap-free case.
REQ-048 The bench SHALL cover: iReset asserted in the cycle a DATA word is accepted -> no write the next cycle, all outputs 0, iStart then restarts normally.
